// File: rtl/anubis_pkg.sv
// Shared Anubis definitions: word geometry, gamma FSM states and the involutive S-box.
package anubis_pkg;

  localparam int unsigned ANUBIS_W     = 128;
  localparam int unsigned ANUBIS_BYTES = 16;

  typedef enum logic [1:0] {
    GAMMA_IDLE = 2'd0,
    GAMMA_BUSY = 2'd1,
    GAMMA_DONE = 2'd2
  } gamma_state_t;

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] ANUBIS_SBOX = {
    128'ha7d3e671d0ac4d793ac991fc1e4754bd,
    128'h8ca57afb63b8ddd4e5b3c5bea9880ca2,
    128'h39df29da2ba8cb4c4b22aa244170a6f9,
    128'h5ae2b0367de433ff6020088b5eab7f78,
    128'h7c2c57d2dc6d7e0d5394c32827065fad,
    128'h675c55480e52ea425b5d305851593c4e,
    128'h388a7214e7c6de508e92d17793459ace,
    128'h2d0362b6b9bf966b3f0712ae4034463e,
    128'hdbcfecccc1a1c0d61df4613b10d868a0,
    128'hb10a696c49fa76c49e9b6e99c2b798bc,
    128'h8f851fb4f8112e00251c2a3d054f7bb2,
    128'h3290af19a3f7739d1574eeca9f0f1b75,
    128'h86849c4a971a65f6ed09bb2683eb6f81,
    128'h046a430117e187f58de3238044166621,
    128'hfed531d935180264f2f156cd82c8baf0,
    128'hefe9e8fd89d7c7b5a42f95130bf3e037
  };

  function automatic logic [7:0] anubis_sbox_lookup(input logic [7:0] x);
    return ANUBIS_SBOX[{~x, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/anubis_sbox.sv
// Combinational Anubis S-box lookup, one byte in, one byte out.
module anubis_sbox
  import anubis_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  assign o_data = anubis_sbox_lookup(i_data);

endmodule

// File: rtl/anubis_gamma_serial.sv
// Iterative Anubis gamma layer: BYTES_PER_CYCLE bytes substituted per clock.
// Optional synchronous abort port enabled by ANUBIS_GAMMA_FLUSH_EN.
module anubis_gamma_serial
  import anubis_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef ANUBIS_GAMMA_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ANUBIS_W-1:0] in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ANUBIS_W-1:0] out_word
);

  localparam int unsigned N      = ANUBIS_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LANE_W = 8 * BYTES_PER_CYCLE;
  localparam int unsigned SH     = $clog2(LANE_W);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N - 1);
  localparam logic [ANUBIS_W-1:0] LANE_MASK = (ANUBIS_W'(1) << LANE_W) - ANUBIS_W'(1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("anubis_gamma_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  gamma_state_t        r_fsm;
  logic [IDX_W-1:0]    r_idx;
  logic [ANUBIS_W-1:0] r_data;

  logic                w_flush;
  logic [6:0]          w_shamt;
  logic [LANE_W-1:0]   w_lane_in;
  logic [LANE_W-1:0]   w_lane_out;
  logic [ANUBIS_W-1:0] w_merged;

`ifdef ANUBIS_GAMMA_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Lane idx covers bytes idx*B .. idx*B+B-1, i.e. bit offset idx * 8B.
  assign w_shamt   = 7'(r_idx) << SH;
  assign w_lane_in = LANE_W'(r_data >> w_shamt);

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    anubis_sbox u_sbox (
      .i_data (w_lane_in[8*g +: 8]),
      .o_data (w_lane_out[8*g +: 8])
    );
  end

  assign w_merged = (r_data & ~(LANE_MASK << w_shamt)) |
                    (ANUBIS_W'(w_lane_out) << w_shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= GAMMA_IDLE;
      r_idx  <= '0;
      r_data <= '0;
    end else if (w_flush) begin
      r_fsm  <= GAMMA_IDLE;
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      case (r_fsm)
        GAMMA_IDLE: begin
          if (in_valid) begin
            r_data <= in_word;
            r_idx  <= '0;
            r_fsm  <= GAMMA_BUSY;
          end
        end
        GAMMA_BUSY: begin
          r_data <= w_merged;
          if (r_idx == IDX_LAST) begin
            r_idx <= '0;
            r_fsm <= GAMMA_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        GAMMA_DONE: begin
          if (out_ready) r_fsm <= GAMMA_IDLE;
        end
        default: r_fsm <= GAMMA_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == GAMMA_IDLE) & ~w_flush;
  assign out_valid = (r_fsm == GAMMA_DONE);
  assign out_word  = r_data;

endmodule

// File: tb/tb_anubis_gamma_serial.sv
// Bench for anubis_gamma_serial at B=1, 4, 16 against a bytewise table model.
module tb_anubis_gamma_serial;

  localparam int NI = 3;
  localparam logic [2047:0] SBOX_TBL = {
    128'ha7d3e671d0ac4d793ac991fc1e4754bd,
    128'h8ca57afb63b8ddd4e5b3c5bea9880ca2,
    128'h39df29da2ba8cb4c4b22aa244170a6f9,
    128'h5ae2b0367de433ff6020088b5eab7f78,
    128'h7c2c57d2dc6d7e0d5394c32827065fad,
    128'h675c55480e52ea425b5d305851593c4e,
    128'h388a7214e7c6de508e92d17793459ace,
    128'h2d0362b6b9bf966b3f0712ae4034463e,
    128'hdbcfecccc1a1c0d61df4613b10d868a0,
    128'hb10a696c49fa76c49e9b6e99c2b798bc,
    128'h8f851fb4f8112e00251c2a3d054f7bb2,
    128'h3290af19a3f7739d1574eeca9f0f1b75,
    128'h86849c4a971a65f6ed09bb2683eb6f81,
    128'h046a430117e187f58de3238044166621,
    128'hfed531d935180264f2f156cd82c8baf0,
    128'hefe9e8fd89d7c7b5a42f95130bf3e037
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_word   [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_word  [NI];
`ifdef ANUBIS_GAMMA_FLUSH_EN
  logic         flush     [NI];
`endif

  int compared = 0;
  int mismatched = 0;
  int unsigned cyc = 0;
  logic [7:0]    sb [256];
  logic [2047:0] tbl;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    anubis_gamma_serial #(
      .BYTES_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 4 : 16))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef ANUBIS_GAMMA_FLUSH_EN
      .flush     (flush[g]),
`endif
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_word   (in_word[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_word  (out_word[g])
    );
  end

  function automatic int n_of(input int k);
    return 16 / (k == 0 ? 1 : (k == 1 ? 4 : 16));
  endfunction

  function automatic logic [127:0] gamma_ref(input logic [127:0] w);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called #1 after an edge with the instance idle; returns the result and latency (-1 on timeout).
  task automatic run_word(input int k, input logic [127:0] w, output logic [127:0] res, output int lat);
    in_word[k]  = w;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_word[k]  = rand128();
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid[k]) begin
        lat = c;
        break;
      end
    end
    res = out_word[k];
  endtask

  task automatic drain(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      compared++;
      if (in_ready[k] !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
      compared++;
      if (out_valid[k] !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
      compared++;
      if (out_word[k] !== 128'h0) begin mismatched++; $display("FAIL reset_out_word[%0d]: got %h want 0", k, out_word[k]); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_word();
    logic [127:0] res;
    int lat;
    run_word(0, 128'h0, res, lat);
    compared++;
    if (res !== {16{8'hA7}}) begin mismatched++; $display("FAIL zero_word: got %h want %h", res, {16{8'hA7}}); end
    compared++;
    if (lat !== 16) begin mismatched++; $display("FAIL zero_latency: got %0d want 16", lat); end
    compared++;
    if (in_ready[0] !== 1'b0) begin mismatched++; $display("FAIL done_in_ready: got %b want 0", in_ready[0]); end
    drain(0);
    compared++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      mismatched++; $display("FAIL after_transfer: got out_valid=%b in_ready=%b want 0/1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_byte_order();
    logic [127:0] res;
    int lat;
    run_word(0, 128'h03020100, res, lat);
    compared++;
    if (res !== 128'hA7A7A7A7_A7A7A7A7_A7A7A7A7_71E6D3A7) begin
      mismatched++; $display("FAIL byte_order: got %h want A7A7A7A7A7A7A7A7A7A7A7A771E6D3A7", res);
    end
    drain(0);
  endtask

  task automatic test_involution();
    logic [127:0] w, res, back;
    int lat;
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 4; r++) begin
        w = rand128();
        run_word(k, w, res, lat);
        compared++;
        if (res !== gamma_ref(w)) begin mismatched++; $display("FAIL gamma[%0d]: got %h want %h", k, res, gamma_ref(w)); end
        compared++;
        if (lat !== n_of(k)) begin mismatched++; $display("FAIL latency[%0d]: got %0d want %0d", k, lat, n_of(k)); end
        drain(k);
        run_word(k, res, back, lat);
        compared++;
        if (back !== w) begin mismatched++; $display("FAIL involution[%0d]: got %h want %h", k, back, w); end
        drain(k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] w, res;
    int lat;
    w = rand128();
    run_word(0, w, res, lat);
    in_word[0]  = rand128();
    in_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      compared++;
      if (out_word[0] !== gamma_ref(w) || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        mismatched++;
        $display("FAIL backpressure_hold: got word=%h ov=%b ir=%b want word=%h ov=1 ir=0",
                 out_word[0], out_valid[0], in_ready[0], gamma_ref(w));
      end
    end
    in_valid[0] = 1'b0;
    drain(0);
    compared++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      mismatched++; $display("FAIL backpressure_release: got ir=%b ov=%b want 1/0", in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] w, res;
    int lat;
    in_word[0]  = rand128();
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_word[0] !== 128'h0) begin
      mismatched++; $display("FAIL mid_busy_reset: got ov=%b ir=%b word=%h want 0/1/0", out_valid[0], in_ready[0], out_word[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    w = rand128();
    run_word(0, w, res, lat);
    compared++;
    if (res !== gamma_ref(w) || lat !== 16) begin
      mismatched++; $display("FAIL post_reset_word: got %h lat=%0d want %h lat=16", res, lat, gamma_ref(w));
    end
    drain(0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] w [3];
    int unsigned acc [3];
    int sent, got;
    for (int i = 0; i < 3; i++) w[i] = rand128();
    sent = 0;
    got = 0;
    out_ready[1] = 1'b1;
    for (int c = 0; c < 100 && got < 3; c++) begin
      if (sent < 3) begin
        in_valid[1] = 1'b1;
        in_word[1]  = w[sent];
      end else begin
        in_valid[1] = 1'b0;
      end
      @(negedge clk);
      if (in_valid[1] && in_ready[1]) begin
        acc[sent] = cyc;
        sent++;
      end
      if (out_valid[1] && out_ready[1]) begin
        compared++;
        if (out_word[1] !== gamma_ref(w[got])) begin
          mismatched++; $display("FAIL b2b_word%0d: got %h want %h", got, out_word[1], gamma_ref(w[got]));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    compared++;
    if (got !== 3) begin
      mismatched++; $display("FAIL b2b_timeout: got %0d words want 3", got);
    end else begin
      for (int i = 1; i < 3; i++) begin
        compared++;
        if (acc[i] - acc[i-1] !== 6) begin
          mismatched++; $display("FAIL b2b_interval%0d: got %0d want 6", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

`ifdef ANUBIS_GAMMA_FLUSH_EN
  task automatic test_flush();
    logic [127:0] res;
    int lat;
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_word[0]  = rand128();
    #1;
    compared++;
    if (in_ready[0] !== 1'b0) begin mismatched++; $display("FAIL flush_in_ready: got %b want 0", in_ready[0]); end
    @(posedge clk); #1;
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    compared++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      mismatched++; $display("FAIL flush_not_accepted: got ov=%b ir=%b want 0/1", out_valid[0], in_ready[0]);
    end
    run_word(0, rand128(), res, lat);
    flush[0]     = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    flush[0]     = 1'b0;
    out_ready[0] = 1'b0;
    compared++;
    if (out_valid[0] !== 1'b0 || out_word[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
      mismatched++; $display("FAIL flush_done: got ov=%b word=%h ir=%b want 0/0/1", out_valid[0], out_word[0], in_ready[0]);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_word[k]   = '0;
      out_ready[k] = 1'b0;
`ifdef ANUBIS_GAMMA_FLUSH_EN
      flush[k]     = 1'b0;
`endif
    end
    tbl = SBOX_TBL;
    for (int i = 0; i < 256; i++) sb[i] = tbl[(255 - i) * 8 +: 8];

    test_reset();
    test_zero_word();
    test_byte_order();
    test_involution();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef ANUBIS_GAMMA_FLUSH_EN
    test_flush();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
